// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg
// Shared definitions for the SPI responder: the frame state encoding,
// register offsets within the bus window, and bit positions inside the
// status register.
// No ports (package).

package spi_slave_pkg;

   typedef enum logic [1:0] {
      idle_e,
      shift_e,
      done_e
   } state_t;

   // Register offsets relative to BaseAddress
   localparam int Write_Byte = 0;
   localparam int Read_Byte  = 1;
   localparam int Status     = 2;
   localparam int Control    = 3;

   // Bit positions inside the status register
   localparam int StatusBusyBit    = 0;
   localparam int StatusRxValidBit = 1;
   localparam int StatusOverrunBit = 2;

endpackage

// File: rtl/spi_slave_sync_edge_detect.sv
// sync_edge_detect
// Brings an asynchronous pin into the system clock domain through two
// flops, then compares against one further delayed copy to produce
// single-cycle rise and fall pulses.  A pin transition appears as a pulse
// that the consumer acts on three clock edges later.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   i_async  asynchronous input pin
//   o_rise   one-cycle pulse on a synchronized 0->1 transition
//   o_fall   one-cycle pulse on a synchronized 1->0 transition

module sync_edge_detect #(
   parameter logic ResetLevel = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic [1:0] r_sync;
   logic       r_prev;

   // Resetting to the pin's idle level keeps reset from fabricating an
   // edge when the pin is sitting at its inactive value.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync <= {2{ResetLevel}};
         r_prev <= ResetLevel;
      end else begin
         r_sync <= {r_sync[0], i_async};
         r_prev <= r_sync[1];
      end
   end

   assign o_rise = r_sync[1] & ~r_prev;
   assign o_fall = ~r_sync[1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// spi_slave
// Memory-mapped SPI mode-0 responder.  The CPU stages a TX word bytewise,
// an external master clocks it out on MISO while MOSI is captured into an
// RX word, and the CPU reads the captured word back bytewise.
// Build option: define SPI_SLAVE_CS_EN to add the spi_cs_n_i port and
// frame on chip-select edges; without it, frames are delimited by bit
// count and an idle timeout aborts partial frames.
// Ports:
//   clk_i       system clock
//   reset_i     synchronous active-high reset
//   address_i   register address
//   data_i      write data
//   data_o      registered read data
//   rd_wr_i     1 = write, 0 = read
//   spi_clk_i   asynchronous SCLK
//   spi_mosi_i  asynchronous MOSI
//   spi_cs_n_i  asynchronous active-low select (SPI_SLAVE_CS_EN only)
//   spi_miso_o  registered MISO

module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int BaseAddress         = 0,
   parameter int BytesPerTransaction = 1,
   parameter int TimeoutCycles       = 1024,
   parameter int address_width       = 16,
   parameter int data_width          = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [address_width-1:0] address_i,
   input  logic [data_width-1:0]    data_i,
   output logic [data_width-1:0]    data_o,
   input  logic                     rd_wr_i,
   input  logic                     spi_clk_i,
   input  logic                     spi_mosi_i,
`ifdef SPI_SLAVE_CS_EN
   input  logic                     spi_cs_n_i,
`endif
   output logic                     spi_miso_o
);

   localparam int N      = 8 * BytesPerTransaction;
   localparam int CountW = $clog2(N + 1);

   state_t r_state;
   state_t w_nextState;

   logic [N-1:0]      r_txData;
   logic [N-1:0]      r_txShift;
   logic [N-1:0]      r_rxShift;
   logic [N-1:0]      r_rxCopy;
   logic [N-1:0]      w_txNext;
   logic [CountW-1:0] r_bitCount;
   logic              r_rxValid;
   logic              r_overrun;
   logic [1:0]        r_mosiSync;

   logic w_sclkRise;
   logic w_sclkFall;
   logic w_frameStart;
   logic w_abort;
   logic w_sample;
   logic w_shiftTx;
   logic w_done;
   logic w_busy;

   logic w_wrByte;
   logic w_wrControl;
   logic w_rdByte;
   logic w_rdStatus;
   logic [7:0]            w_status;
   logic [data_width-1:0] w_readData;

   sync_edge_detect #(.ResetLevel(1'b0)) u_sclkSync (
      .i_clk   (clk_i),
      .i_reset (reset_i),
      .i_async (spi_clk_i),
      .o_rise  (w_sclkRise),
      .o_fall  (w_sclkFall)
   );

   // MOSI only needs a level, taken from the same synchronizer depth as
   // SCLK so the sampled bit lines up with the detected rising edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_mosiSync <= 2'b00;
      end else begin
         r_mosiSync <= {r_mosiSync[0], spi_mosi_i};
      end
   end

`ifdef SPI_SLAVE_CS_EN
   logic w_csRise;
   logic w_csFall;

   sync_edge_detect #(.ResetLevel(1'b1)) u_csSync (
      .i_clk   (clk_i),
      .i_reset (reset_i),
      .i_async (spi_cs_n_i),
      .o_rise  (w_csRise),
      .o_fall  (w_csFall)
   );

   assign w_frameStart = w_csFall;
   assign w_abort      = w_csRise;
`else
   localparam int TimerW = $clog2(TimeoutCycles) + 1;

   logic [TimerW-1:0] r_timer;
   logic              w_timeout;

   // Counts clocks since the last SCLK edge while a frame is open; a
   // master that stalls mid-frame is assumed gone and the frame dropped.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_timer <= '0;
      end else if (r_state != shift_e || w_sclkRise || w_sclkFall) begin
         r_timer <= '0;
      end else if (!w_timeout) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   assign w_timeout    = (r_timer == TimerW'(TimeoutCycles));
   assign w_frameStart = w_sclkRise;
   assign w_abort      = w_timeout;
`endif

   // Register decode; the bus has no strobe, so idle cycles must park the
   // address outside the window.
   assign w_wrByte    = rd_wr_i  && (address_i == address_width'(BaseAddress + Write_Byte));
   assign w_wrControl = rd_wr_i  && (address_i == address_width'(BaseAddress + Control));
   assign w_rdByte    = !rd_wr_i && (address_i == address_width'(BaseAddress + Read_Byte));
   assign w_rdStatus  = !rd_wr_i && (address_i == address_width'(BaseAddress + Status));

   // Staging shifts bytes in from the right; a single-byte frame simply
   // replaces the word.
   if (BytesPerTransaction == 1) begin : g_singleByte
      assign w_txNext = data_i[7:0];
   end else begin : g_multiByte
      assign w_txNext = {r_txData[N-9:0], data_i[7:0]};
   end

   // Frame state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= idle_e;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Frame sequencing.  Without chip select, the rising edge that opens a
   // frame is also its first data bit, so it is sampled in idle.
   always_comb begin
      w_nextState = r_state;
      w_sample    = 1'b0;
      w_shiftTx   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         idle_e: begin
            if (w_frameStart) begin
               w_nextState = shift_e;
`ifndef SPI_SLAVE_CS_EN
               w_sample    = 1'b1;
`endif
            end
         end
         shift_e: begin
            if (w_abort) begin
               w_nextState = idle_e;
            end else begin
               if (w_sclkRise) begin
                  w_sample = 1'b1;
                  if (r_bitCount == CountW'(N - 1)) begin
                     w_nextState = done_e;
                  end
               end
               if (w_sclkFall) begin
                  w_shiftTx = 1'b1;
               end
            end
         end
         done_e: begin
            w_done      = 1'b1;
            w_nextState = idle_e;
         end
         default: begin
            w_nextState = idle_e;
         end
      endcase
   end

   assign w_busy = (r_state != idle_e);

   // Read mux feeding the registered data_o.
   always_comb begin
      w_status                   = 8'h00;
      w_status[StatusBusyBit]    = w_busy;
      w_status[StatusRxValidBit] = r_rxValid;
      w_status[StatusOverrunBit] = r_overrun;
      w_readData                 = '0;
      if (w_rdByte) begin
         w_readData = data_width'(r_rxCopy[N-1 -: 8]);
      end else if (w_rdStatus) begin
         w_readData = data_width'(w_status);
      end
   end

   // Datapath.  Outside a frame the TX shifter tracks staging so the first
   // MISO bit is already present before the first rising edge; once the
   // frame opens, staging writes no longer reach the shifter.  A staging
   // write landing in the completion cycle takes priority over the clear.
   // A Read_Byte in the completion cycle returns the old byte while the
   // copy picks up the new word.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_txData   <= '0;
         r_txShift  <= '0;
         r_rxShift  <= '0;
         r_rxCopy   <= '0;
         r_bitCount <= '0;
         r_rxValid  <= 1'b0;
         r_overrun  <= 1'b0;
         spi_miso_o <= 1'b0;
         data_o     <= '0;
      end else begin
         data_o <= w_readData;

         if (w_wrByte) begin
            r_txData <= w_txNext;
         end else if (w_done) begin
            r_txData <= '0;
         end

         if (r_state == idle_e) begin
            r_txShift  <= r_txData;
            spi_miso_o <= r_txData[N-1];
         end else begin
            if (w_shiftTx) begin
               r_txShift <= r_txShift << 1;
            end
            spi_miso_o <= r_txShift[N-1];
         end

         if (r_state == shift_e && w_abort) begin
            r_rxShift <= '0;
         end else if (w_sample) begin
            r_rxShift <= {r_rxShift[N-2:0], r_mosiSync[1]};
         end

         if (w_sample) begin
            r_bitCount <= r_bitCount + 1'b1;
         end else if (r_state != shift_e) begin
            r_bitCount <= '0;
         end

         if (w_done) begin
            r_rxCopy  <= r_rxShift;
            r_overrun <= r_rxValid;
            r_rxValid <= 1'b1;
         end else if (w_rdByte) begin
            r_rxCopy  <= r_rxCopy << 8;
            r_rxValid <= 1'b0;
         end else if (w_wrControl && data_i[0]) begin
            r_overrun <= 1'b0;
            r_rxValid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/spi_slave.md
# spi_slave

Memory-mapped SPI responder (mode 0: CPOL=0, CPHA=0) on the CPU register bus. It is the far-end counterpart of `spi_master`, for FPGA-to-FPGA links and for loopback test of the master. External SCLK/MOSI (and optional CS_N) are oversampled in the `clk_i` domain. Each frame simultaneously shifts a CPU-staged TX word out on MISO and captures MOSI into an RX word that the CPU reads back bytewise.

## Interface
- `BaseAddress`, 0: register window base.
- `BytesPerTransaction`, 1: frame length in bytes; N = 8*BytesPerTransaction bits.
- `TimeoutCycles`, 1024: idle `clk_i` cycles without an SCLK edge that abort a partial frame (no-CS build only).
- `address_width`, 16: bus address width.
- `data_width`, 8: bus data width.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  system clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `address_i`  in  address_width  register address.
- `data_i`  in  data_width  write data.
- `data_o`  out  data_width  registered read data.
- `rd_wr_i`  in  1  1 = write, 0 = read.
- `spi_clk_i`  in  1  asynchronous SCLK.
- `spi_mosi_i`  in  1  asynchronous MOSI.
- `spi_cs_n_i`  in  1  asynchronous active-low select; present only with `SPI_SLAVE_CS_EN`.
- `spi_miso_o`  out  1  MISO, registered.

## Operation
- Registers:
  - Base+0 write: shift byte into TX staging, `tx_data <= {tx_data[N-9:0], data_i}`. For BytesPerTransaction = 1, `tx_data <= data_i`.
  - Base+1 read: `data_o <=` MSB byte of the RX copy; copy shifts left 8; `rx_valid` clears.
  - Base+2 read: status {5'b0, overrun, rx_valid, busy}.
  - Base+3 write: bit0 = 1 clears `overrun` and `rx_valid`.
  - Other reads return 0. Other writes are ignored.
- States:
  - `idle_e`
    - `tx_shift <= tx_data`; `spi_miso_o <= tx_data[N-1]`; bit count 0.
    - Frame start moves to `shift_e`. With CS, frame start is the CS_N fall. Without CS, it is the first SCLK rise, which is also sampled.
  - `shift_e`
    - SCLK rise: `rx_shift <= {rx_shift[N-2:0], mosi}`; count+1.
    - SCLK fall: `tx_shift <<= 1`; `spi_miso_o <=` new MSB.
    - Count reaches N on a rise: go to `done_e`.
    - Abort returns to `idle_e` and discards `rx_shift`. Abort is CS_N rise (CS build) or the TimeoutCycles expiry (no-CS build).
  - `done_e` (1 cycle)
    - RX copy `<= rx_shift`.
    - `overrun <= rx_valid`, then `rx_valid <= 1`.
    - Clear `tx_data`, unless a Base+0 write occurs this cycle; the write wins.
    - Return to `idle_e`.
- `busy` is 1 in `shift_e` and `done_e`.
- A Base+0 write during a frame affects only staging, never the in-flight `tx_shift`.
- If `done_e` coincides with a Base+1 read:
  - `data_o` returns the old copy byte.
  - The copy takes the new word.
  - `rx_valid` ends at 1.
- Extra SCLK edges after N bits and before CS_N rise are ignored.
- Reset:
  - State `idle_e`.
  - `data_o`, `spi_miso_o`, `tx_data`, `tx_shift`, `rx_shift`, RX copy, `busy`, `rx_valid`, `overrun` and the counters are all 0.
  - Reset mid-frame drops the frame; the remaining SCLK edges are ignored until the next frame start.

## Timing
- SCLK, MOSI and CS_N each pass a 2-flop synchronizer. SCLK edge detect adds one flop, so an edge is acted on 3 `clk_i` cycles after the pin transition.
- MOSI is sampled from the same synchronized stage as SCLK, so there is no skew between them.
- `spi_miso_o` changes 4 cycles after the SCLK fall.
- Required: SCLK high and low phases each ≥ 6 `clk_i` cycles. `spi_master` with divider ≥ 3 meets this.
- Bus reads are 1-cycle registered, as in the rest of the bus.
- `rx_valid` rises 1 cycle after the final rising edge is detected.

## Configuration
- `SPI_SLAVE_CS_EN` defined:
  - The `spi_cs_n_i` port exists and frames start and end on its edges.
  - The timeout logic is not built.
- `SPI_SLAVE_CS_EN` undefined (the default, matching `spi_master`, which has no CS):
  - There is no CS port.
  - Framing is by bit count only.
  - A counter of `$clog2(TimeoutCycles)+1` bits resets on every SCLK edge. Reaching TimeoutCycles in `shift_e` aborts the frame.

## Structure
- Package `spi_slave_pkg` holds:
  - `state_t` enum {idle_e, shift_e, done_e};
  - register offset constants Write_Byte = 0, Read_Byte = 1, Status = 2, Control = 3;
  - status bit indices.
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus rise/fall pulse outputs. It is instanced for SCLK and CS_N; MOSI uses its synchronized output only.

## Test plan
- Loopback with `spi_master` (BytesPerTransaction = 1, FPGAClkSpeed 50 MHz, SPIClkSpeed 1 MHz):
  - Stimulus: slave staged 0xA5, master sends 0x3C.
  - Response: master reads 0xA5; slave status = 0x02; slave Read_Byte = 0x3C; then status = 0x00.
- BytesPerTransaction = 2:
  - Stimulus: stage 0x12 then 0x34; master sends 0xBEEF.
  - Response: MISO carries 0x1234 MSB first; Read_Byte returns 0xBE then 0xEF.
- Overrun:
  - Stimulus: two frames with no Read_Byte between them.
  - Response: status = 0x06 and the copy holds the second word; Control write 0x01 gives status 0x00.
- Abort:
  - Stimulus: 5 SCLK cycles, then CS_N rises (CS build) or 1024 idle cycles pass (no-CS build).
  - Response: `rx_valid` stays 0; busy returns to 0; the next full frame is captured correctly.
- Reset mid-frame:
  - Stimulus: assert `reset_i` for 1 cycle after 3 bits.
  - Response: `spi_miso_o` = 0 and `data_o` = 0 the next cycle; status 0x00.
- Collision:
  - Stimulus: Base+0 write of 0x77 in the `done_e` cycle.
  - Response: `tx_data` = 0x77 and the next frame shifts out 0x77.
